// File: rtl/clk_div_gen.sv
// clk_div_gen: programmable clock divider with tick pulse and divisor changes
// that wait for a counter wrap.
module clk_div_gen #(
  parameter int          CNT_W       = 32,
  parameter int unsigned DIV_DEFAULT = 100_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_in,
  output logic             out_clk,
  output logic             tick,
  output logic [CNT_W-1:0] count,
  output logic             pend,
  output logic             load_err
);
  localparam logic [CNT_W-1:0] DEF = CNT_W'(DIV_DEFAULT);
  logic [CNT_W-1:0] c_q, c_d, div_q, div_d, p_q, p_d;
  logic             pend_q, pend_d, clk_q, clk_d, tick_q, err_q;
  logic             wrap, ld_ok;
  // D is never zero, so D-1 stays within CNT_W bits
  assign wrap  = en && (c_q == div_q - CNT_W'(1));
  assign ld_ok = div_load && (div_in != '0);
  always_comb begin
    c_d    = c_q;
    div_d  = div_q;
    p_d    = p_q;
    pend_d = pend_q;
    clk_d  = clk_q;
    if (wrap) begin
      c_d   = '0;
      clk_d = ~clk_q;
      if (ld_ok) begin
        div_d  = div_in;
        pend_d = 1'b0;
      end else if (pend_q) begin
        div_d  = p_q;
        pend_d = 1'b0;
      end
    end else begin
      if (en) c_d = c_q + CNT_W'(1);
      else if (pend_q) begin
        div_d  = p_q;
        c_d    = '0;
        pend_d = 1'b0;
      end
      // a fresh load always lands in P, even while an older P commits
      if (ld_ok) begin
        p_d    = div_in;
        pend_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      c_q    <= '0;
      div_q  <= DEF;
      p_q    <= DEF;
      pend_q <= 1'b0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      c_q    <= c_d;
      div_q  <= div_d;
      p_q    <= p_d;
      pend_q <= pend_d;
      clk_q  <= clk_d;
      tick_q <= wrap;
      err_q  <= div_load && (div_in == '0);
    end
  end
  assign out_clk  = clk_q;
  assign tick     = tick_q;
  assign count    = c_q;
  assign pend     = pend_q;
  assign load_err = err_q;
endmodule
